// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter and its bench.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } tx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Full frame duration in clock cycles, start bit through last stop bit.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned data_bits,
                                               input int unsigned parity_mode,
                                               input int unsigned stop_bits);
    return (1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, strobes on the last
// and second-to-last cycle of each bit period. Shared with the planned receiver.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic bit_end,
  output logic bit_pre
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_end = enable && (cnt == LAST);
  assign bit_pre = enable && (cnt == PRE);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready handshake and back-to-back frames.
// Define UART_TX_BREAK_EN to add the TX_BREAK input and line-break generation.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 TX_DATA_VALID,
  input  logic [DATA_BITS-1:0] TX_BYTE,
`ifdef UART_TX_BREAK_EN
  input  logic                 TX_BREAK,
`endif
  output logic                 O_TX_READY,
  output logic                 O_TX_SERIAL,
  output logic                 O_TX_BUSY,
  output logic                 O_TX_DONE
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_MODE > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_tx_param: illegal parameter combination");
  end

  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 ready_q;
  logic                 last_stop;
  logic                 accept;
  logic                 baud_clear;
  logic                 bit_end;
  logic                 bit_pre;

  assign last_stop = (STOP_BITS == 2) ? stop_idx : 1'b1;

`ifdef UART_TX_BREAK_EN
  logic brk_mark;
  logic brk_release;
  // Break wins over a pending frame in IDLE, so ready is withheld that cycle.
  assign O_TX_READY  = ready_q && !(TX_BREAK && state == IDLE);
  assign brk_release = (state == BREAK) && !brk_mark && !TX_BREAK;
  assign baud_clear  = accept || brk_release;
`else
  assign O_TX_READY  = ready_q;
  assign baud_clear  = accept;
`endif

  assign accept = TX_DATA_VALID && O_TX_READY;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .clear  (baud_clear),
    .enable (state != IDLE),
    .bit_end(bit_end),
    .bit_pre(bit_pre)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= IDLE;
      O_TX_SERIAL <= 1'b1;
      ready_q     <= 1'b1;
      O_TX_BUSY   <= 1'b0;
      O_TX_DONE   <= 1'b0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_mark    <= 1'b0;
`endif
    end else begin
      O_TX_DONE <= 1'b0;
      // Accept is only possible in IDLE or the final stop cycle, so it overrides the state step.
      if (accept) begin
        state       <= START;
        O_TX_SERIAL <= 1'b0;
        ready_q     <= 1'b0;
        O_TX_BUSY   <= 1'b1;
        shreg       <= TX_BYTE;
        par_bit     <= (^TX_BYTE) ^ (PARITY_MODE == PARITY_ODD);
        bit_idx     <= '0;
        stop_idx    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (TX_BREAK) begin
              state       <= BREAK;
              O_TX_SERIAL <= 1'b0;
              ready_q     <= 1'b0;
              brk_mark    <= 1'b0;
            end
`endif
          end
          START: begin
            if (bit_end) begin
              state       <= DATA;
              O_TX_SERIAL <= shreg[0];
              shreg       <= shreg >> 1;
              bit_idx     <= '0;
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bit_idx == LAST_BIT) begin
                if (PARITY_MODE != PARITY_NONE) begin
                  state       <= PARITY;
                  O_TX_SERIAL <= par_bit;
                end else begin
                  state       <= STOP;
                  O_TX_SERIAL <= 1'b1;
                  stop_idx    <= 1'b0;
                end
              end else begin
                bit_idx     <= bit_idx + 1'b1;
                O_TX_SERIAL <= shreg[0];
                shreg       <= shreg >> 1;
              end
            end
          end
          PARITY: begin
            if (bit_end) begin
              state       <= STOP;
              O_TX_SERIAL <= 1'b1;
              stop_idx    <= 1'b0;
            end
          end
          STOP: begin
            // Done/ready are registered, so they are raised one cycle ahead of bit_end.
            if (bit_pre && last_stop) begin
              O_TX_DONE <= 1'b1;
              ready_q   <= 1'b1;
            end
            if (bit_end) begin
              if (!last_stop) begin
                stop_idx <= 1'b1;
              end else begin
                state     <= IDLE;
                O_TX_BUSY <= 1'b0;
              end
            end
          end
`ifdef UART_TX_BREAK_EN
          BREAK: begin
            if (!brk_mark) begin
              if (!TX_BREAK) begin
                brk_mark    <= 1'b1;
                O_TX_SERIAL <= 1'b1;
              end
            end else if (bit_end) begin
              state    <= IDLE;
              ready_q  <= 1'b1;
              brk_mark <= 1'b0;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Four transmitter configurations driven in parallel, each compared cycle by cycle
// against a queue of expected line levels built from the frame format.
module tb_uart_tx_param;
  import uart_pkg::*;

  typedef struct packed {
    logic lvl;
    logic last;
  } ev_t;

  localparam int MAXC = 2500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int CPB = (g == 0) ? 4 : (g == 3) ? 2 : 3;
    localparam int DB  = (g == 0) ? 8 : (g == 3) ? 9 : 7;
    localparam int PM  = (g == 0) ? 0 : (g == 2) ? 2 : 1;
    localparam int SB  = (g == 0 || g == 3) ? 1 : 2;
    localparam int LEN = int'(frame_cycles(CPB, DB, PM, SB));
    localparam int RSTPT = (LEN / CPB - 4) * CPB - 1;
    localparam logic [8:0] D0 = (g == 0) ? 9'h0A5 : (g < 3) ? 9'h003 : 9'h16B;

    logic          rst;
    logic          valid;
    logic [DB-1:0] byte_in;
    logic          ready, ser, busy, done;
    logic          fin = 1'b0;

    uart_tx_param #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB),
      .PARITY_MODE (PM),
      .STOP_BITS   (SB)
    ) dut (
      .CLOCK        (clk),
      .RESET        (rst),
      .TX_DATA_VALID(valid),
      .TX_BYTE      (byte_in),
`ifdef UART_TX_BREAK_EN
      .TX_BREAK     (1'b0),
`endif
      .O_TX_READY   (ready),
      .O_TX_SERIAL  (ser),
      .O_TX_BUSY    (busy),
      .O_TX_DONE    (done)
    );

    initial begin
      ev_t         q[$];
      ev_t         hd;
      logic [12:0] fr;
      logic [8:0]  tmp;
      logic        p, acc, rdy, e_ser, e_rdy, e_busy, e_done;
      int          nb, ph, cnt2;
      rst = 1'b1; valid = 1'b0; byte_in = '0;
      ph = 0; cnt2 = 0; acc = 1'b0;
      for (int c = 0; c < MAXC; c++) begin
        @(posedge clk);
        // Reference step: what the edge just did to the expected line schedule.
        acc = 1'b0;
        if (rst) begin
          q.delete();
        end else begin
          rdy = (q.size() == 0) || q[0].last;
          acc = valid && rdy;
          if (q.size() != 0) void'(q.pop_front());
          if (acc) begin
            fr = '0; nb = 0;
            fr[nb] = 1'b0; nb++;
            for (int i = 0; i < DB; i++) begin fr[nb] = byte_in[i]; nb++; end
            if (PM != 0) begin
              p = ^byte_in;
              if (PM == 2) p = ~p;
              fr[nb] = p; nb++;
            end
            for (int s = 0; s < SB; s++) begin fr[nb] = 1'b1; nb++; end
            for (int b = 0; b < nb; b++)
              for (int k = 0; k < CPB; k++)
                q.push_back('{lvl: fr[b], last: (b == nb - 1 && k == CPB - 1)});
          end
        end

        @(negedge clk);
        if (q.size() == 0) begin
          e_ser = 1'b1; e_rdy = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        end else begin
          hd = q[0];
          e_ser = hd.lvl; e_rdy = hd.last; e_busy = 1'b1; e_done = hd.last;
        end
        check($sformatf("g%0d.c%0d.serial", g, c), {31'd0, ser},   {31'd0, e_ser});
        check($sformatf("g%0d.c%0d.ready",  g, c), {31'd0, ready}, {31'd0, e_rdy});
        check($sformatf("g%0d.c%0d.busy",   g, c), {31'd0, busy},  {31'd0, e_busy});
        check($sformatf("g%0d.c%0d.done",   g, c), {31'd0, done},  {31'd0, e_done});

        case (ph)
          0: if (c >= 2) begin
               rst = 1'b0; valid = 1'b1; tmp = D0; byte_in = tmp[DB-1:0]; ph = 1;
             end
          1: begin
               if (acc) valid = 1'b0;
               if (!valid) byte_in = DB'($urandom);
               if (!valid && q.size() == 0) begin
                 ph = 2; cnt2 = 0; valid = 1'b1; tmp = 9'h055; byte_in = tmp[DB-1:0];
               end
             end
          2: begin
               if (acc) begin
                 cnt2++;
                 if (cnt2 == 1) begin tmp = 9'h0AA; byte_in = tmp[DB-1:0]; end
                 else valid = 1'b0;
               end
               if (cnt2 == 2 && q.size() == 0) begin
                 ph = 3; valid = 1'b1; byte_in = DB'($urandom);
               end
             end
          3: begin
               if (acc) valid = 1'b0;
               if (!valid) byte_in = DB'($urandom);
               if (!valid && q.size() == RSTPT) begin rst = 1'b1; ph = 5; end
             end
          5: begin rst = 1'b0; ph = 4; end
          4: begin
               valid   = ($urandom_range(0, 2) != 0);
               byte_in = DB'($urandom);
               rst     = ($urandom_range(0, 299) == 0);
               if (c >= MAXC - LEN - 4) begin ph = 6; valid = 1'b0; rst = 1'b0; end
             end
          default: valid = 1'b0;
        endcase
      end
      fin = 1'b1;
    end
  end

  initial begin
    logic [3:0] all;
    all = '0;
    for (int i = 0; i < MAXC + 1000 && all != 4'hF; i++) begin
      @(posedge clk);
      all = {g_cfg[3].fin, g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin};
    end
    if (all != 4'hF) check("timeout", {28'd0, all}, 32'hF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
